// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// The peripheral decoder and the arbiter agree on these encodings.
package uart_tx_arbiter_pkg;

    // Arbiter FSM encodings
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // UART register map (byte offsets)
    localparam logic [7:0] UART_ADDR_DATA   = 8'h00;
    localparam logic [7:0] UART_ADDR_CTRL   = 8'h04;
    localparam logic [7:0] UART_ADDR_STATUS = 8'h08;
    localparam logic [7:0] UART_ADDR_BAUD   = 8'h0C;

    // Width of a requester index
    localparam int GID_W = 3;

    // Next round-robin start point after serving requester g
    function automatic logic [GID_W-1:0] rr_next(
        input logic [GID_W-1:0] g,
        input int               nreq
    );
        if (int'(g) >= nreq - 1) begin
            return '0;
        end
        return g + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Picks the first set request at or above rr_ptr, wrapping at NREQ.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] rr_ptr,
    output logic [GID_W-1:0] grant,
    output logic             valid
);

    int best;
    int off;

    // Smallest rotated distance from rr_ptr among set requests wins
    always_comb begin
        grant = '0;
        best  = NREQ;
        off   = 0;
        valid = |req;
        for (int j = 0; j < NREQ; j++) begin
            if (j >= int'(rr_ptr)) begin
                off = j - int'(rr_ptr);
            end else begin
                off = j + NREQ - int'(rr_ptr);
            end
            if (req[j] && (off < best)) begin
                best  = off;
                grant = GID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between requesters.
// Latches a byte, pulses tx_enable, waits for completion or timeout, acks.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TO_W    = 18,
    parameter int TIMEOUT = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_status
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WD_MAX  = TO_W'(TIMEOUT);

    state_e           state;
    state_e           state_nxt;
    logic [GID_W-1:0] rr_ptr;
    logic [GID_W-1:0] pick;
    logic             pick_vld;
    logic [7:0]       pick_byte;
    logic [TO_W-1:0]  wd;
    logic             wd_hit;
    logic             timeout;

    uart_tx_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .valid  (pick_vld)
    );

    // Byte of the requester the encoder currently selects
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == GID_W'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    // Completion wins over a watchdog expiry in the same cycle
    assign wd_hit  = (wd >= WD_LAST);
    assign timeout = (state == S_WAIT) && !tx_status && wd_hit;

    // Next-state and decoded outputs
    always_comb begin
        state_nxt = state;
        tx_enable = 1'b0;
        busy      = (state != S_IDLE);
        ack       = '0;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                tx_enable = 1'b1;
                state_nxt = S_GUARD;
            end
            S_GUARD: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tx_status || wd_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                for (int i = 0; i < NREQ; i++) begin
                    ack[i] = (grant_id == GID_W'(i));
                end
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant/byte latch in IDLE and pointer rotation in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id <= '0;
            tx_data  <= '0;
            rr_ptr   <= '0;
        end else begin
            if ((state == S_IDLE) && pick_vld) begin
                grant_id <= pick;
                tx_data  <= pick_byte;
            end
            if (state == S_DONE) begin
                rr_ptr <= rr_next(grant_id, NREQ);
            end
        end
    end

    // Watchdog: cleared on send, counts WAIT cycles, saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (state == S_SEND) begin
            wd <= '0;
        end else if ((state == S_WAIT) && (wd != WD_MAX)) begin
            wd <= wd + 1'b1;
        end
    end

    // Sticky error flag; a new timeout beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Table of transfers plus hand sequences for guard, timeout and reset.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 50;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [2:0]        grant_id;
    logic              busy;
    logic              err;
    logic              err_clr;
    logic [7:0]        tx_data;
    logic              tx_enable;
    logic              tx_status;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         delay;
        logic [1:0] clr;
        logic [2:0] g;
        logic [7:0] data;
        logic       err;
        logic       errclr;
    } vec_t;

    vec_t       vecs[10];
    logic [1:0] exp_q[$];
    int         checks;
    int         errors;
    int         exp_total;
    int         ack_pulses;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TO_W    (18),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_status (tx_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every ack pulse the DUT produces
    always @(negedge clk) begin
        if (|ack) begin
            ack_pulses <= ack_pulses + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] g);
        exp_q.push_back(2'(2'b01 << g));
        exp_total++;
    endtask

    task automatic pop_chk(input string name);
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(ack), 32'(e));
        end
    endtask

    task automatic wait_tx(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_enable) seen = 1'b1;
        end
        chk("tx_enable_seen", 32'(seen), 32'd1);
    endtask

    // One full transfer; returns with DUT back in IDLE
    task automatic do_xfer(input vec_t v);
        bit seen;
        req      = v.req;
        req_data = {v.d1, v.d0};
        wait_tx(seen);
        if (!seen) return;
        chk("grant_id", 32'(grant_id), 32'(v.g));
        chk("tx_data", 32'(tx_data), 32'(v.data));
        push_exp(v.g);
        @(negedge clk);
        chk("tx_enable_width", 32'(tx_enable), 32'd0);
        chk("busy_mid", 32'(busy), 32'd1);
        if (v.delay >= 0) begin
            repeat (v.delay - 1) @(negedge clk);
            tx_status = 1'b1;
            @(negedge clk);
            tx_status = 1'b0;
        end else begin
            repeat (TO) @(negedge clk);
            if (v.errclr) err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        pop_chk("ack");
        chk("err", 32'(err), 32'(v.err));
        req = req & ~v.clr;
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("ack_after", 32'(ack), 32'd0);
    endtask

    initial begin
        bit seen;
        checks     = 0;
        errors     = 0;
        exp_total  = 0;
        ack_pulses = 0;
        reset      = 1'b0;
        req        = '0;
        req_data   = '0;
        err_clr    = 1'b0;
        tx_status  = 1'b0;

        vecs[0] = '{2'b01, 8'h55, 8'h00, 10, 2'b01, 3'd0, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 8'h00, 8'hB2,  6, 2'b10, 3'd1, 8'hB2, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 8'hA1, 8'hB2,  4, 2'b00, 3'd0, 8'hA1, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 8'hA1, 8'hB2,  4, 2'b00, 3'd1, 8'hB2, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 8'hA1, 8'hB2,  4, 2'b00, 3'd0, 8'hA1, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 8'hA1, 8'hB2,  4, 2'b11, 3'd1, 8'hB2, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 8'h00, 8'hE7, -1, 2'b10, 3'd1, 8'hE7, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 8'h77, 8'h00, -1, 2'b01, 3'd0, 8'h77, 1'b1, 1'b1};
        vecs[8] = '{2'b11, 8'hC3, 8'hD4,  3, 2'b01, 3'd0, 8'hC3, 1'b0, 1'b0};
        vecs[9] = '{2'b10, 8'hC3, 8'hD4,  5, 2'b10, 3'd1, 8'hD4, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single request, then alternating service under a held 2'b11
        for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

        // Stale completion held high across the grant
        tx_status = 1'b1;
        req       = 2'b01;
        req_data  = {8'h00, 8'h3C};
        wait_tx(seen);
        if (seen) begin
            chk("guard_grant", 32'(grant_id), 32'd0);
            chk("guard_tx_data", 32'(tx_data), 32'h3C);
            push_exp(3'd0);
            @(negedge clk);
            chk("guard_ack_k1", 32'(ack), 32'd0);
            @(negedge clk);
            chk("guard_ack_k2", 32'(ack), 32'd0);
            @(negedge clk);
            pop_chk("guard_ack_k3");
        end
        tx_status = 1'b0;
        req       = 2'b00;
        @(negedge clk);
        chk("guard_busy_after", 32'(busy), 32'd0);

        // Watchdog abort, then a plain clear
        do_xfer(vecs[6]);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Clear coincident with a second abort: set wins
        do_xfer(vecs[7]);

        // Reset while waiting for completion
        req      = 2'b01;
        req_data = {8'h00, 8'h11};
        wait_tx(seen);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);

        for (int i = 8; i < 10; i++) do_xfer(vecs[i]);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ack_pulse_count", 32'(ack_pulses), 32'(exp_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
